// File: rtl/exu_dec_pkg.sv
// -----------------------------------------------------------------------------
// exu_dec_pkg
// Shared definitions for the RV32I(M) decode stage: instruction/register-index
// widths, the layout of the grouped decode-info bus, the major opcode enum and
// immediate extraction helpers.
//
// Decode-info bus (DECINFO_WIDTH bits):
//   [1:0]  group code (ALU / BJP / AGU / MULDIV)
//   [14:2] group-specific one-hot/field bits, ranges listed below
//
// Optional feature macro used by the decode core: EXU_DEC_RV32M_EN
// -----------------------------------------------------------------------------
package exu_dec_pkg;

  localparam int INSTR_SIZE    = 32;
  localparam int RFIDX_WIDTH   = 5;
  localparam int DECINFO_WIDTH = 15;

  // Group field
  localparam int DECINFO_GRP_LSB = 0;
  localparam int DECINFO_GRP_MSB = 1;
  localparam logic [1:0] DECINFO_GRP_ALU    = 2'd0;
  localparam logic [1:0] DECINFO_GRP_BJP    = 2'd1;
  localparam logic [1:0] DECINFO_GRP_AGU    = 2'd2;
  localparam logic [1:0] DECINFO_GRP_MULDIV = 2'd3;

  // ALU group bits
  localparam int DECINFO_ALU_ADD    = 2;
  localparam int DECINFO_ALU_SUB    = 3;
  localparam int DECINFO_ALU_XOR    = 4;
  localparam int DECINFO_ALU_SLL    = 5;
  localparam int DECINFO_ALU_SRL    = 6;
  localparam int DECINFO_ALU_SRA    = 7;
  localparam int DECINFO_ALU_OR     = 8;
  localparam int DECINFO_ALU_AND    = 9;
  localparam int DECINFO_ALU_SLT    = 10;
  localparam int DECINFO_ALU_SLTU   = 11;
  localparam int DECINFO_ALU_LUI    = 12;
  localparam int DECINFO_ALU_OP2IMM = 13;
  localparam int DECINFO_ALU_OP1PC  = 14;

  // BJP group bits
  localparam int DECINFO_BJP_JUMP  = 2;
  localparam int DECINFO_BJP_BPRDT = 3;
  localparam int DECINFO_BJP_BEQ   = 4;
  localparam int DECINFO_BJP_BNE   = 5;
  localparam int DECINFO_BJP_BLT   = 6;
  localparam int DECINFO_BJP_BGE   = 7;
  localparam int DECINFO_BJP_BLTU  = 8;
  localparam int DECINFO_BJP_BGEU  = 9;

  // AGU group bits
  localparam int DECINFO_AGU_LOAD     = 2;
  localparam int DECINFO_AGU_STORE    = 3;
  localparam int DECINFO_AGU_SIZE_LSB = 4;
  localparam int DECINFO_AGU_SIZE_MSB = 5;
  localparam int DECINFO_AGU_USIGN    = 6;

  // MULDIV group bits (consecutive, indexed by funct3)
  localparam int DECINFO_MULDIV_MUL    = 2;
  localparam int DECINFO_MULDIV_MULH   = 3;
  localparam int DECINFO_MULDIV_MULHSU = 4;
  localparam int DECINFO_MULDIV_MULHU  = 5;
  localparam int DECINFO_MULDIV_DIV    = 6;
  localparam int DECINFO_MULDIV_DIVU   = 7;
  localparam int DECINFO_MULDIV_REM    = 8;
  localparam int DECINFO_MULDIV_REMU   = 9;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/exu_dec_core.sv
// -----------------------------------------------------------------------------
// exu_dec_core
// Purely combinational RV32I(M) instruction decoder.
// Ports:
//   i_instr, i_prdt_taken            raw instruction and its branch prediction
//   o_rs1en/o_rs2en/o_rdwen          register-file enables
//   o_rs1idx/o_rs2idx/o_rdidx        raw register index fields
//   o_info                           grouped decode bus (see exu_dec_pkg)
//   o_imm, o_bjp_imm                 selected immediate, branch/jump offset
//   o_illegal, o_bjp/o_jal/o_jalr/o_bxx
// Macro EXU_DEC_RV32M_EN: when defined, OP with funct7=0000001 decodes into
// the MULDIV group; otherwise those encodings are illegal.
// An illegal encoding zeroes info, enables, flags and immediates.
// -----------------------------------------------------------------------------
module exu_dec_core
  import exu_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_SIZE-1:0]    i_instr,
  input  logic                     i_prdt_taken,
  output logic                     o_rs1en,
  output logic                     o_rs2en,
  output logic                     o_rdwen,
  output logic [RFIDX_WIDTH-1:0]   o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]   o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]   o_rdidx,
  output logic [DECINFO_WIDTH-1:0] o_info,
  output logic [XLEN-1:0]          o_imm,
  output logic [XLEN-1:0]          o_bjp_imm,
  output logic                     o_illegal,
  output logic                     o_bjp,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_bxx
);

  opcode_e            w_opc;
  logic [2:0]         w_f3;
  logic [6:0]         w_f7;
  logic [DECINFO_WIDTH-1:0] w_info;
  logic [31:0]        w_imm32;
  logic [31:0]        w_bimm32;
  logic               w_ill;
  logic               w_rs1en, w_rs2en, w_rdwen;
  logic               w_jal, w_jalr, w_bxx;

  assign w_opc    = opcode_e'(i_instr[6:0]);
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign o_rdidx  = i_instr[11:7];
  assign o_rs1idx = i_instr[19:15];
  assign o_rs2idx = i_instr[24:20];

  always_comb begin
    w_info   = '0;
    w_imm32  = '0;
    w_bimm32 = '0;
    w_ill    = 1'b0;
    w_rs1en  = 1'b0;
    w_rs2en  = 1'b0;
    w_rdwen  = 1'b0;
    w_jal    = 1'b0;
    w_jalr   = 1'b0;
    w_bxx    = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_ALU;
        w_info[DECINFO_ALU_LUI]    = 1'b1;
        w_info[DECINFO_ALU_OP2IMM] = 1'b1;
        w_rdwen = 1'b1;
        w_imm32 = imm_u(i_instr);
      end
      OPC_AUIPC: begin
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_ALU;
        w_info[DECINFO_ALU_ADD]    = 1'b1;
        w_info[DECINFO_ALU_OP1PC]  = 1'b1;
        w_info[DECINFO_ALU_OP2IMM] = 1'b1;
        w_rdwen = 1'b1;
        w_imm32 = imm_u(i_instr);
      end
      OPC_JAL: begin
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_BJP;
        w_info[DECINFO_BJP_JUMP]  = 1'b1;
        w_info[DECINFO_BJP_BPRDT] = i_prdt_taken;
        w_rdwen  = 1'b1;
        w_jal    = 1'b1;
        w_imm32  = imm_j(i_instr);
        w_bimm32 = imm_j(i_instr);
      end
      OPC_JALR: begin
        w_ill = (w_f3 != 3'd0);
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_BJP;
        w_info[DECINFO_BJP_JUMP]  = 1'b1;
        w_info[DECINFO_BJP_BPRDT] = i_prdt_taken;
        w_rs1en  = 1'b1;
        w_rdwen  = 1'b1;
        w_jalr   = 1'b1;
        w_imm32  = imm_i(i_instr);
        w_bimm32 = imm_i(i_instr);
      end
      OPC_BRANCH: begin
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_BJP;
        w_info[DECINFO_BJP_BPRDT] = i_prdt_taken;
        case (w_f3)
          3'd0:    w_info[DECINFO_BJP_BEQ]  = 1'b1;
          3'd1:    w_info[DECINFO_BJP_BNE]  = 1'b1;
          3'd4:    w_info[DECINFO_BJP_BLT]  = 1'b1;
          3'd5:    w_info[DECINFO_BJP_BGE]  = 1'b1;
          3'd6:    w_info[DECINFO_BJP_BLTU] = 1'b1;
          3'd7:    w_info[DECINFO_BJP_BGEU] = 1'b1;
          default: w_ill = 1'b1;
        endcase
        w_rs1en  = 1'b1;
        w_rs2en  = 1'b1;
        w_bxx    = 1'b1;
        w_imm32  = imm_b(i_instr);
        w_bimm32 = imm_b(i_instr);
      end
      OPC_LOAD: begin
        // Legal widths: LB LH LW LBU LHU
        w_ill = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_AGU;
        w_info[DECINFO_AGU_LOAD] = 1'b1;
        w_info[DECINFO_AGU_SIZE_MSB:DECINFO_AGU_SIZE_LSB] = w_f3[1:0];
        w_info[DECINFO_AGU_USIGN] = w_f3[2];
        w_rs1en = 1'b1;
        w_rdwen = 1'b1;
        w_imm32 = imm_i(i_instr);
      end
      OPC_STORE: begin
        w_ill = (w_f3 > 3'd2);
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_AGU;
        w_info[DECINFO_AGU_STORE] = 1'b1;
        w_info[DECINFO_AGU_SIZE_MSB:DECINFO_AGU_SIZE_LSB] = w_f3[1:0];
        w_rs1en = 1'b1;
        w_rs2en = 1'b1;
        w_imm32 = imm_s(i_instr);
      end
      OPC_OPIMM: begin
        w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_ALU;
        w_info[DECINFO_ALU_OP2IMM] = 1'b1;
        w_rs1en = 1'b1;
        w_rdwen = 1'b1;
        w_imm32 = imm_i(i_instr);
        case (w_f3)
          3'd0: w_info[DECINFO_ALU_ADD]  = 1'b1;
          // funct7 must be zero; a set bit 25 would be a shamt >= 32
          3'd1: begin
            w_info[DECINFO_ALU_SLL] = 1'b1;
            w_ill = (w_f7 != 7'b0000000);
          end
          3'd2: w_info[DECINFO_ALU_SLT]  = 1'b1;
          3'd3: w_info[DECINFO_ALU_SLTU] = 1'b1;
          3'd4: w_info[DECINFO_ALU_XOR]  = 1'b1;
          3'd5: begin
            if (w_f7 == 7'b0000000)      w_info[DECINFO_ALU_SRL] = 1'b1;
            else if (w_f7 == 7'b0100000) w_info[DECINFO_ALU_SRA] = 1'b1;
            else                         w_ill = 1'b1;
          end
          3'd6: w_info[DECINFO_ALU_OR]   = 1'b1;
          default: w_info[DECINFO_ALU_AND] = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_rs1en = 1'b1;
        w_rs2en = 1'b1;
        w_rdwen = 1'b1;
        if (w_f7 == 7'b0000000) begin
          w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_ALU;
          case (w_f3)
            3'd0:    w_info[DECINFO_ALU_ADD]  = 1'b1;
            3'd1:    w_info[DECINFO_ALU_SLL]  = 1'b1;
            3'd2:    w_info[DECINFO_ALU_SLT]  = 1'b1;
            3'd3:    w_info[DECINFO_ALU_SLTU] = 1'b1;
            3'd4:    w_info[DECINFO_ALU_XOR]  = 1'b1;
            3'd5:    w_info[DECINFO_ALU_SRL]  = 1'b1;
            3'd6:    w_info[DECINFO_ALU_OR]   = 1'b1;
            default: w_info[DECINFO_ALU_AND]  = 1'b1;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'd0) begin
          w_info[DECINFO_ALU_SUB] = 1'b1;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'd5) begin
          w_info[DECINFO_ALU_SRA] = 1'b1;
`ifdef EXU_DEC_RV32M_EN
        end else if (w_f7 == 7'b0000001) begin
          w_info[DECINFO_GRP_MSB:DECINFO_GRP_LSB] = DECINFO_GRP_MULDIV;
          w_info[DECINFO_MULDIV_MUL + int'(w_f3)] = 1'b1;
`endif
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal words still flow down the pipe but carry no operation.
    if (w_ill) begin
      w_info   = '0;
      w_imm32  = '0;
      w_bimm32 = '0;
      w_rs1en  = 1'b0;
      w_rs2en  = 1'b0;
      w_rdwen  = 1'b0;
      w_jal    = 1'b0;
      w_jalr   = 1'b0;
      w_bxx    = 1'b0;
    end
  end

  assign o_info    = w_info;
  assign o_imm     = XLEN'($signed(w_imm32));
  assign o_bjp_imm = XLEN'($signed(w_bimm32));
  assign o_illegal = w_ill;
  assign o_rs1en   = w_rs1en;
  assign o_rs2en   = w_rs2en;
  assign o_rdwen   = w_rdwen;
  assign o_jal     = w_jal;
  assign o_jalr    = w_jalr;
  assign o_bxx     = w_bxx;
  assign o_bjp     = w_jal | w_jalr | w_bxx;

endmodule

// File: rtl/exu_dec_stage.sv
// -----------------------------------------------------------------------------
// exu_dec_stage
// Registered decode stage: DEPTH-entry instruction queue between IFU and EXU,
// a single combinational decoder on the queue-head / bypass mux, and an output
// register handed to dispatch under valid/ready.
// Ports:
//   clk, rst_n (async, active-low)
//   i_valid/i_ready/i_instr/i_pc/i_prdt_taken   fetch side
//   i_flush                                      discard queue + output reg
//   o_valid/o_ready                              dispatch handshake
//   o_rs*/o_rd*, o_info, o_imm, o_bjp_imm, o_pc, o_illegal, o_bjp/jal/jalr/bxx
//   o_cnt                                        queue occupancy (excl. out reg)
// Macro EXU_DEC_RV32M_EN (see exu_dec_core) enables M-extension decode.
// -----------------------------------------------------------------------------
module exu_dec_stage
  import exu_dec_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [INSTR_SIZE-1:0]      i_instr,
  input  logic [PC_SIZE-1:0]         i_pc,
  input  logic                       i_prdt_taken,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic                       o_rs1en,
  output logic                       o_rs2en,
  output logic                       o_rdwen,
  output logic [RFIDX_WIDTH-1:0]     o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]     o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]     o_rdidx,
  output logic [DECINFO_WIDTH-1:0]   o_info,
  output logic [XLEN-1:0]            o_imm,
  output logic [XLEN-1:0]            o_bjp_imm,
  output logic [PC_SIZE-1:0]         o_pc,
  output logic                       o_illegal,
  output logic                       o_bjp,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_bxx,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_SIZE-1:0] r_q_instr [DEPTH];
  logic [PC_SIZE-1:0]    r_q_pc    [DEPTH];
  logic                  r_q_prdt  [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                     r_o_valid;
  logic                     r_rs1en, r_rs2en, r_rdwen;
  logic [RFIDX_WIDTH-1:0]   r_rs1idx, r_rs2idx, r_rdidx;
  logic [DECINFO_WIDTH-1:0] r_info;
  logic [XLEN-1:0]          r_imm, r_bjp_imm;
  logic [PC_SIZE-1:0]       r_pc;
  logic                     r_illegal, r_bjp, r_jal, r_jalr, r_bxx;

  logic                     w_q_nempty, w_push, w_ld_en, w_ld_q, w_ld_byp, w_ld, w_q_wr;
  logic [INSTR_SIZE-1:0]    w_sel_instr;
  logic [PC_SIZE-1:0]       w_sel_pc;
  logic                     w_sel_prdt;
  logic                     w_rs1en, w_rs2en, w_rdwen;
  logic [RFIDX_WIDTH-1:0]   w_rs1idx, w_rs2idx, w_rdidx;
  logic [DECINFO_WIDTH-1:0] w_info;
  logic [XLEN-1:0]          w_imm, w_bjp_imm;
  logic                     w_illegal, w_bjp, w_jal, w_jalr, w_bxx;

  // i_ready comes only from the count register, never from o_ready, so a
  // full queue refuses input even in a cycle where dispatch pops.
  assign i_ready    = (r_cnt != CNT_W'(DEPTH));
  assign w_q_nempty = (r_cnt != '0);
  assign w_push     = i_valid & i_ready & ~i_flush;
  assign w_ld_en    = ~r_o_valid | o_ready;
  assign w_ld_q     = w_ld_en & w_q_nempty & ~i_flush;
  // Bypass only when the queue is empty, which keeps ordering FIFO.
  assign w_ld_byp   = w_ld_en & ~w_q_nempty & w_push;
  assign w_ld       = w_ld_q | w_ld_byp;
  assign w_q_wr     = w_push & ~w_ld_byp;

  assign w_sel_instr = w_q_nempty ? r_q_instr[r_rd_ptr] : i_instr;
  assign w_sel_pc    = w_q_nempty ? r_q_pc[r_rd_ptr]    : i_pc;
  assign w_sel_prdt  = w_q_nempty ? r_q_prdt[r_rd_ptr]  : i_prdt_taken;

  exu_dec_core #(.XLEN(XLEN)) u_core (
    .i_instr      (w_sel_instr),
    .i_prdt_taken (w_sel_prdt),
    .o_rs1en      (w_rs1en),
    .o_rs2en      (w_rs2en),
    .o_rdwen      (w_rdwen),
    .o_rs1idx     (w_rs1idx),
    .o_rs2idx     (w_rs2idx),
    .o_rdidx      (w_rdidx),
    .o_info       (w_info),
    .o_imm        (w_imm),
    .o_bjp_imm    (w_bjp_imm),
    .o_illegal    (w_illegal),
    .o_bjp        (w_bjp),
    .o_jal        (w_jal),
    .o_jalr       (w_jalr),
    .o_bxx        (w_bxx)
  );

  // Queue storage: contents are only meaningful below r_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (w_q_wr) begin
      r_q_instr[r_wr_ptr] <= i_instr;
      r_q_pc[r_wr_ptr]    <= i_pc;
      r_q_prdt[r_wr_ptr]  <= i_prdt_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_q_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_ld_q) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_q_wr) - CNT_W'(w_ld_q);
    end
  end

  // Output register: holds while stalled (o_valid & ~o_ready).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_rs1en   <= 1'b0;
      r_rs2en   <= 1'b0;
      r_rdwen   <= 1'b0;
      r_rs1idx  <= '0;
      r_rs2idx  <= '0;
      r_rdidx   <= '0;
      r_info    <= '0;
      r_imm     <= '0;
      r_bjp_imm <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
      r_bjp     <= 1'b0;
      r_jal     <= 1'b0;
      r_jalr    <= 1'b0;
      r_bxx     <= 1'b0;
    end else if (i_flush) begin
      r_o_valid <= 1'b0;
    end else begin
      if (w_ld_en) r_o_valid <= w_ld;
      if (w_ld) begin
        r_rs1en   <= w_rs1en;
        r_rs2en   <= w_rs2en;
        r_rdwen   <= w_rdwen;
        r_rs1idx  <= w_rs1idx;
        r_rs2idx  <= w_rs2idx;
        r_rdidx   <= w_rdidx;
        r_info    <= w_info;
        r_imm     <= w_imm;
        r_bjp_imm <= w_bjp_imm;
        r_pc      <= w_sel_pc;
        r_illegal <= w_illegal;
        r_bjp     <= w_bjp;
        r_jal     <= w_jal;
        r_jalr    <= w_jalr;
        r_bxx     <= w_bxx;
      end
    end
  end

  assign o_valid   = r_o_valid;
  assign o_rs1en   = r_rs1en;
  assign o_rs2en   = r_rs2en;
  assign o_rdwen   = r_rdwen;
  assign o_rs1idx  = r_rs1idx;
  assign o_rs2idx  = r_rs2idx;
  assign o_rdidx   = r_rdidx;
  assign o_info    = r_info;
  assign o_imm     = r_imm;
  assign o_bjp_imm = r_bjp_imm;
  assign o_pc      = r_pc;
  assign o_illegal = r_illegal;
  assign o_bjp     = r_bjp;
  assign o_jal     = r_jal;
  assign o_jalr    = r_jalr;
  assign o_bxx     = r_bxx;
  assign o_cnt     = r_cnt;

endmodule
